// File: rtl/branch_predict_if.sv
// branch_predict_if: fetch/decode-side signals of the branch predictor
interface branch_predict_if;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        stall;
    logic        id_taken;
    logic [31:0] id_target;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [15:0] mispred_cnt;

    modport master (
        output if_pc, if_instr, if_valid, stall, id_taken, id_target,
        input  pred_taken, pred_target, flush, redirect_pc, mispred_cnt
    );
    modport slave (
        input  if_pc, if_instr, if_valid, stall, id_taken, id_target,
        output pred_taken, pred_target, flush, redirect_pc, mispred_cnt
    );
endinterface

// File: rtl/branch_predict.sv
// branch_predict: 2-bit BHT predictor with IF predecode, ID resolution and mispredict counter
module branch_predict #(
    parameter int IDX_W = 6
) (
    input logic             clk,
    input logic             rst,
    branch_predict_if.slave bp
);
    logic [5:0]       op;
    logic             is_cond;
    logic             is_jump;
    logic [31:0]      pc4;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bht_q [2**IDX_W];
    logic             id_valid_q;
    logic             id_cond_q;
    logic             id_jump_q;
    logic             id_pred_q;
    logic [31:0]      id_target_q;
    logic [31:0]      id_pc4_q;
    logic [IDX_W-1:0] id_idx_q;
    logic [15:0]      cnt_q;
    logic [15:0]      cnt_d;
    logic [1:0]       ctr;
    logic [1:0]       ctr_d;
    logic             resolve;
    logic             mispred;

    // REGIMM branches are those with rt[3:1]==000 (BLTZ/BGEZ and their -AL forms)
    assign op      = bp.if_instr[31:26];
    assign is_cond = (op == 6'b000001 && bp.if_instr[19:17] == 3'b000) || op[5:2] == 4'b0001;
    assign is_jump = op[5:1] == 5'b00001;
    assign pc4     = bp.if_pc + 32'd4;
    assign idx     = bp.if_pc[IDX_W+1:2];

    assign bp.pred_taken  = bp.if_valid & (is_jump | (is_cond & bht_q[idx][1]));
    assign bp.pred_target = is_jump ? {pc4[31:28], bp.if_instr[25:0], 2'b00}
                                    : pc4 + {{14{bp.if_instr[15]}}, bp.if_instr[15:0], 2'b00};

    assign resolve        = id_valid_q & ~bp.stall & (id_cond_q | id_jump_q | bp.id_taken);
    assign mispred        = (id_pred_q != bp.id_taken) |
                            (id_pred_q & bp.id_taken & (id_target_q != bp.id_target));
    assign bp.flush       = resolve & mispred;
    assign bp.redirect_pc = bp.id_taken ? bp.id_target : id_pc4_q;
    assign bp.mispred_cnt = cnt_q;

    assign ctr   = bht_q[id_idx_q];
    assign ctr_d = bp.id_taken ? ((ctr == 2'b11) ? ctr : ctr + 2'd1)
                               : ((ctr == 2'b00) ? ctr : ctr - 2'd1);
    assign cnt_d = (bp.flush && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**IDX_W; i++) bht_q[i] <= 2'b01;
            id_valid_q  <= 1'b0;
            id_cond_q   <= 1'b0;
            id_jump_q   <= 1'b0;
            id_pred_q   <= 1'b0;
            id_target_q <= '0;
            id_pc4_q    <= '0;
            id_idx_q    <= '0;
            cnt_q       <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (!bp.stall) begin
                id_valid_q  <= bp.if_valid & ~bp.flush;
                id_cond_q   <= is_cond;
                id_jump_q   <= is_jump;
                id_pred_q   <= bp.pred_taken;
                id_target_q <= bp.pred_target;
                id_pc4_q    <= pc4;
                id_idx_q    <= idx;
                if (id_valid_q && id_cond_q) bht_q[id_idx_q] <= ctr_d;
            end
        end
    end
endmodule
